mult_seq_ctrl: RTL and testbench

- FSM controller that sequences an 8-bit shift-and-add multiplier built from universal shift registers sharing one tri-state data bus.
- Registers used: accumulator (A, high product), multiplier/quotient (Q, low product), multiplicand register (M), carry flop.
- Emits per-cycle mode, output-enable and load strobes for each register. Guarantees at most one bus driver per cycle.
- Reports busy/done to the host.

---
 rtl/mult_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Moore FSM sequencing an 8-bit shift-and-add multiplier over a shared tri-state bus.
// Control strobes are decoded from the next state and registered, so they change only on clock edges.
module mult_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic q_lsb,
  output logic a_s1,
  output logic a_s0,
  output logic a_oe,
  output logic q_s1,
  output logic q_s0,
  output logic q_oe,
  output logic m_ld,
  output logic ext_oe,
  output logic sum_oe,
  output logic cy_clr,
  output logic cy_ld,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic [1:0] a_mode;
    logic       a_oe;
    logic [1:0] q_mode;
    logic       q_oe;
    logic       m_ld;
    logic       ext_oe;
    logic       sum_oe;
    logic       cy_clr;
    logic       cy_ld;
    logic       busy;
    logic       done;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{default: 1'b0};

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r;
  ctrl_t            ctrl_next_s, ctrl_r;

  // Moore output decode for a given state; bus enables are mutually exclusive by construction.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      S_IDLE:  c = CTRL_IDLE;
      S_LOAD: begin
        c.busy   = 1'b1;
        c.ext_oe = 1'b1;
        c.q_mode = 2'b10;
        c.m_ld   = 1'b1;
        c.a_mode = 2'b11;
        c.cy_clr = 1'b1;
      end
      S_TEST:  c.busy = 1'b1;
      S_ADD: begin
        c.busy   = 1'b1;
        c.sum_oe = 1'b1;
        c.a_mode = 2'b10;
        c.cy_ld  = 1'b1;
      end
      S_SHIFT: begin
        c.busy   = 1'b1;
        c.a_mode = 2'b01;
        c.q_mode = 2'b01;
        c.cy_clr = 1'b1;
      end
      S_DONE: begin
        c.busy = 1'b1;
        c.done = 1'b1;
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Iteration counter: loaded in LOAD, stepped down once per SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == S_LOAD) begin
      cnt_r <= CNT_W'(WIDTH);
    end else if (state_r == S_SHIFT) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) next_state_s = S_LOAD;
        else       next_state_s = S_IDLE;
      end
      S_LOAD:  next_state_s = S_TEST;
      S_TEST: begin
        if (q_lsb) next_state_s = S_ADD;
        else       next_state_s = S_SHIFT;
      end
      S_ADD:   next_state_s = S_SHIFT;
      S_SHIFT: begin
        if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) next_state_s = S_DONE;
        else                                     next_state_s = S_TEST;
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered strobes align with it
  always_comb begin
    ctrl_next_s = decode(next_state_s);
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r <= CTRL_IDLE;
    end else begin
      ctrl_r <= ctrl_next_s;
    end
  end

  assign a_s1   = ctrl_r.a_mode[1];
  assign a_s0   = ctrl_r.a_mode[0];
  assign a_oe   = ctrl_r.a_oe;
  assign q_s1   = ctrl_r.q_mode[1];
  assign q_s0   = ctrl_r.q_mode[0];
  assign q_oe   = ctrl_r.q_oe;
  assign m_ld   = ctrl_r.m_ld;
  assign ext_oe = ctrl_r.ext_oe;
  assign sum_oe = ctrl_r.sum_oe;
  assign cy_clr = ctrl_r.cy_clr;
  assign cy_ld  = ctrl_r.cy_ld;
  assign busy   = ctrl_r.busy;
  assign done   = ctrl_r.done;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: drives a behavioural A/Q/M/carry datapath from the controller
// strobes and checks products, latency and strobe counts against plain arithmetic.
module tb_mult_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic q_lsb;
  logic a_s1, a_s0, a_oe, q_s1, q_s0, q_oe, m_ld, ext_oe, sum_oe, cy_clr, cy_ld, busy, done;

  int total = 0;
  int bad = 0;

  logic [7:0] mcand = 8'h00;
  logic [7:0] mplier = 8'h00;
  logic [7:0] ra = 8'h00, rq = 8'h00, rm = 8'h00;
  logic       rcy = 1'b0;
  logic [8:0] sum;

  mult_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q_lsb(q_lsb),
    .a_s1(a_s1), .a_s0(a_s0), .a_oe(a_oe), .q_s1(q_s1), .q_s0(q_s0), .q_oe(q_oe),
    .m_ld(m_ld), .ext_oe(ext_oe), .sum_oe(sum_oe), .cy_clr(cy_clr), .cy_ld(cy_ld),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Datapath model: universal shift registers plus carry flop, steered by the strobes
  assign sum   = {1'b0, ra} + {1'b0, rm};
  assign q_lsb = rq[0];
  always @(posedge clk) begin
    case ({a_s1, a_s0})
      2'b11:   ra <= 8'h00;
      2'b10:   ra <= sum_oe ? sum[7:0] : 8'hxx;
      2'b01:   ra <= {rcy, ra[7:1]};
      default: ra <= ra;
    endcase
    case ({q_s1, q_s0})
      2'b11:   rq <= 8'h00;
      2'b10:   rq <= ext_oe ? mplier : 8'hxx;
      2'b01:   rq <= {ra[0], rq[7:1]};
      default: rq <= rq;
    endcase
    if (m_ld) rm <= mcand;
    if (cy_clr)     rcy <= 1'b0;
    else if (cy_ld) rcy <= sum[8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle invariants: one bus driver at most, readback enables idle, single-cycle done
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("bus_onehot", 32'(int'(a_oe) + int'(q_oe) + int'(ext_oe) + int'(sum_oe) <= 1), 32'd1);
      chk("aq_oe_zero", {30'd0, a_oe, q_oe}, 32'd0);
      chk("done_pulse", {31'd0, done & prev_done}, 32'd0);
      if (!busy)
        chk("idle_quiet", {19'd0, a_s1, a_s0, q_s1, q_s0, m_ld, ext_oe, sum_oe, cy_clr, cy_ld,
                           done, 3'd0}, 32'd0);
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  function automatic logic [12:0] outs();
    return {a_s1, a_s0, a_oe, q_s1, q_s0, q_oe, m_ld, ext_oe, sum_oe, cy_clr, cy_ld, busy, done};
  endfunction

  function automatic int popcnt(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  // One complete multiply; start is dropped once LOAD is seen
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output logic [15:0] prod,
                        output int busy_n, output int adds, output int cylds, output bit ok);
    bit seen = 1'b0;
    @(negedge clk);
    mcand = a; mplier = b; start = 1'b1;
    busy_n = 0; adds = 0; cylds = 0; prod = 16'h0000;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (busy) begin busy_n++; start = 1'b0; end
      if (sum_oe) adds++;
      if (cy_ld) cylds++;
      if (done) begin seen = 1'b1; prod = {ra, rq}; end
    end
    start = 1'b0;
    ok = seen;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          busy_n;
    int          adds;
  } vec_t;

  vec_t vecs[6];
  logic [15:0] p;
  int bn, ad, cl;
  bit ok;

  initial begin
    vecs[0] = '{8'h0D, 8'h0B, 16'h008F, 21, 3};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 26, 8};
    vecs[2] = '{8'h00, 8'h5A, 16'h0000, 22, 4};
    vecs[3] = '{8'h5A, 8'h00, 16'h0000, 18, 0};
    vecs[4] = '{8'h03, 8'h05, 16'h000F, 20, 2};
    vecs[5] = '{8'h80, 8'h01, 16'h0080, 19, 1};

    #2;
    chk("reset_outs", {19'd0, outs()}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", {19'd0, outs()}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, p, bn, ad, cl, ok);
      chk("vec_done", {31'd0, ok}, 32'd1);
      chk("vec_prod", {16'd0, p}, {16'd0, vecs[i].prod});
      chk("vec_busy", bn, vecs[i].busy_n);
      chk("vec_adds", ad, vecs[i].adds);
      chk("vec_cyld", cl, vecs[i].adds);
    end

    // Random operands against arithmetic product and latency formula
    for (int i = 0; i < 20; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      run_op(a, b, p, bn, ad, cl, ok);
      chk("rnd_done", {31'd0, ok}, 32'd1);
      chk("rnd_prod", {16'd0, p}, {16'd0, 16'(a) * 16'(b)});
      chk("rnd_busy", bn, 2 + 16 + popcnt(b));
      chk("rnd_adds", ad, popcnt(b));
    end

    // Start held high: back-to-back 3x5 with exactly one IDLE cycle between done and LOAD
    begin
      int ndone = 0, done_cyc = -1;
      @(negedge clk);
      mcand = 8'h03; mplier = 8'h05; start = 1'b1;
      for (int c = 0; c < 120 && ndone < 3; c++) begin
        @(negedge clk);
        if (ext_oe && done_cyc >= 0) chk("b2b_gap", c - done_cyc, 2);
        if (done) begin
          ndone++;
          done_cyc = c;
          chk("b2b_prod", {16'd0, ra, rq}, 32'h000F);
        end
        if (done_cyc >= 0 && c == done_cyc + 1) chk("b2b_idle", {31'd0, busy}, 32'd0);
      end
      chk("b2b_count", ndone, 3);
      start = 1'b0;
      repeat (30) @(negedge clk);
    end

    // Reset asserted during the 4th SHIFT, then a clean 2x3
    begin
      int nshift = 0;
      bit hit = 1'b0;
      @(negedge clk);
      mcand = 8'h0D; mplier = 8'hFF; start = 1'b1;
      for (int c = 0; c < 60 && !hit; c++) begin
        @(negedge clk);
        if (busy) start = 1'b0;
        if ({a_s1, a_s0} == 2'b01) nshift++;
        if (nshift == 4) begin
          hit = 1'b1;
          rst_n = 1'b0;
          #1;
          chk("rst_outs", {19'd0, outs()}, 32'd0);
        end
      end
      chk("rst_reached", {31'd0, hit}, 32'd1);
      start = 1'b0;
      @(negedge clk);
      chk("rst_hold", {19'd0, outs()}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_idle", {19'd0, outs()}, 32'd0);
      run_op(8'h02, 8'h03, p, bn, ad, cl, ok);
      chk("post_rst_done", {31'd0, ok}, 32'd1);
      chk("post_rst_prod", {16'd0, p}, 32'h0006);
      chk("post_rst_busy", bn, 20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
